// File: rtl/ps2_scancode_rx_if.sv
// Key-event bus from the PS/2 receiver to the key-to-note decoder.
// One event per completed scan code, or one frame_error pulse; there is no back-pressure.
interface ps2_scancode_rx_if;
    logic [7:0] code;
    logic       code_valid;
    logic       code_break;
    logic       code_extended;
    logic       frame_error;

    modport master (
        output code,
        output code_valid,
        output code_break,
        output code_extended,
        output frame_error
    );

    modport slave (
        input code,
        input code_valid,
        input code_break,
        input code_extended,
        input frame_error
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host deframer; folds E0/F0 prefixes into flags and emits one event per scan code.
// Outputs register two cycles after the synchronised clock fall; receive-only, never stalls.
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_dat,
    ps2_scancode_rx_if.master key
);
    localparam int             CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          break_pend_q, break_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic [7:0]    code_q, code_d;
    logic          code_valid_q, code_valid_d;
    logic          code_break_q, code_break_d;
    logic          code_ext_q, code_ext_d;
    logic          frame_error_q, frame_error_d;
    logic          fall;

    assign fall = clk_prev_q & ~clk_s2_q;

    always_comb begin
        state_d       = state_q;
        clk_s1_d      = ps2_clk;
        clk_s2_d      = clk_s1_q;
        clk_prev_d    = clk_s2_q;
        dat_s1_d      = ps2_dat;
        dat_s2_d      = dat_s1_q;
        bit_cnt_d     = bit_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        break_pend_d  = break_pend_q;
        ext_pend_d    = ext_pend_q;
        code_d        = code_q;
        code_valid_d  = 1'b0;
        code_break_d  = code_break_q;
        code_ext_d    = code_ext_q;
        frame_error_d = 1'b0;

        if (state_q == IDLE || fall) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != CNT_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if ((^{shift_q, parity_q}) && dat_s2_q) begin
                        if (shift_q == 8'hF0) begin
                            break_pend_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else begin
                            code_d       = shift_q;
                            code_break_d = break_pend_q;
                            code_ext_d   = ext_pend_q;
                            code_valid_d = 1'b1;
                            break_pend_d = 1'b0;
                            ext_pend_d   = 1'b0;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        break_pend_d  = 1'b0;
                        ext_pend_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fall in the same cycle as expiry takes the bit instead of timing out.
        if (state_q != IDLE && !fall && idle_cnt_q == CNT_LAST) begin
            state_d       = IDLE;
            idle_cnt_d    = '0;
            frame_error_d = 1'b1;
            break_pend_d  = 1'b0;
            ext_pend_d    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= IDLE;
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_prev_q    <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            bit_cnt_q     <= 3'd0;
            idle_cnt_q    <= '0;
            shift_q       <= 8'h00;
            parity_q      <= 1'b0;
            break_pend_q  <= 1'b0;
            ext_pend_q    <= 1'b0;
            code_q        <= 8'h00;
            code_valid_q  <= 1'b0;
            code_break_q  <= 1'b0;
            code_ext_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            clk_prev_q    <= clk_prev_d;
            dat_s1_q      <= dat_s1_d;
            dat_s2_q      <= dat_s2_d;
            bit_cnt_q     <= bit_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            break_pend_q  <= break_pend_d;
            ext_pend_q    <= ext_pend_d;
            code_q        <= code_d;
            code_valid_q  <= code_valid_d;
            code_break_q  <= code_break_d;
            code_ext_q    <= code_ext_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign key.code          = code_q;
    assign key.code_valid    = code_valid_q;
    assign key.code_break    = code_break_q;
    assign key.code_extended = code_ext_q;
    assign key.frame_error   = frame_error_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: stimulus queues expected events, a monitor pops and compares.
module tb_ps2_scancode_rx;
    localparam int TO   = 100;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_scancode_rx_if key_if();

    ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .key      (key_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   err_cyc = -1;
    int   last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (key_if.code_valid || key_if.frame_error)) begin
            exp_t e;
            chk("pulse_exclusive", {31'd0, key_if.code_valid & key_if.frame_error}, 32'd0);
            if (key_if.frame_error) err_cyc = cyc;
            if (q.size() == 0) begin
                chk("unexpected_event", {30'd0, key_if.frame_error, key_if.code_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("event_kind", {31'd0, key_if.frame_error}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    chk("code", {24'd0, key_if.code}, {24'd0, e.code});
                    chk("code_break", {31'd0, key_if.code_break}, {31'd0, e.brk});
                    chk("code_extended", {31'd0, key_if.code_extended}, {31'd0, e.ext});
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        wait_cycles(HALF);
    endtask

    task automatic expect_code(input logic [7:0] c, input bit brk, input bit ext);
        exp_t e;
        e.is_err = 1'b0; e.code = c; e.brk = brk; e.ext = ext;
        q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1; e.code = 8'h00; e.brk = 1'b0; e.ext = 1'b0;
        q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_code"}, {24'd0, key_if.code}, 32'd0);
        chk({tag, "_valid"}, {31'd0, key_if.code_valid}, 32'd0);
        chk({tag, "_break"}, {31'd0, key_if.code_break}, 32'd0);
        chk({tag, "_ext"}, {31'd0, key_if.code_extended}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, key_if.frame_error}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cycles(3);
        reset = 1'b0;
        check_idle_outputs("reset");
        wait_cycles(5);

        // Plain make code
        expect_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11);

        // Break sequence, then a fresh make
        send_frame(8'hF0, 1'b0, 11);
        expect_code(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 11);
        expect_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11);

        // Extended break
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        expect_code(8'h75, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 11);

        // Parity error clears the pending break
        send_frame(8'hF0, 1'b0, 11);
        expect_err();
        send_frame(8'h1C, 1'b1, 11);
        expect_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11);

        // Timeout after start + 4 data bits
        err_cyc = -1;
        expect_err();
        send_frame(8'h1C, 1'b0, 5);
        for (int i = 0; i < 300 && err_cyc < 0; i++) wait_cycles(1);
        chk("timeout_seen", {31'd0, err_cyc >= 0}, 32'd1);
        if (err_cyc >= 0) chk("timeout_delay", err_cyc - last_fall_cyc, 32'd103);
        wait_cycles(10);
        expect_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11);

        // Reset mid-frame, then a clean 0x23
        send_frame(8'h23, 1'b0, 6);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        check_idle_outputs("midreset");
        wait_cycles(5);
        expect_code(8'h23, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 11);

        wait_cycles(20);
        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receive front end for the synth's keyboard input path. It samples the raw PS/2 clock and data lines in the CLOCK_50 domain and deframes 11-bit device-to-host frames. It folds the 0xE0 extended prefix and the 0xF0 break prefix into flags, then presents one key event per completed scan code to the downstream key-to-note decoder. It is receive-only: it never drives the PS/2 lines.

## Interface
- TIMEOUT_CYCLES, default 50000: CLOCK_50 cycles allowed between consecutive falling PS/2 clock edges inside a frame (1 ms) before the frame is abandoned.
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous to CLOCK_50.
- ps2_dat  in  1  raw PS/2 data line, asynchronous to CLOCK_50.
- code  out  8  last completed scan code, excluding prefix bytes; holds until the next code_valid.
- code_valid  out  1  one-cycle pulse; code, code_break and code_extended are new in this cycle.
- code_break  out  1  1 when an 0xF0 prefix preceded code (key release).
- code_extended  out  1  1 when an 0xE0 prefix preceded code.
- frame_error  out  1  one-cycle pulse on parity error, stop-bit error or timeout.

## Operation
- Input synchronisation: each of ps2_clk and ps2_dat passes through a 2-flop synchroniser.
- Falling-edge detect: fall = (previous synced clk == 1) && (synced clk == 0). Data is sampled only on fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with dat=0 (start bit), go to DATA and clear bit_cnt. On fall with dat=1, ignore and stay in IDLE.
  - DATA: on fall, shift dat in LSB-first. After the 8th bit (bit_cnt==7), go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, evaluate the frame, then return to IDLE regardless of outcome.
- Frame check: valid when XOR(data[7:0], parity) == 1 (odd parity) and the stop bit == 1. Otherwise pulse frame_error, clear both pending flags and produce no code_valid.
- Prefix handling for a valid byte:
  - 0xF0: set break_pend; no code_valid.
  - 0xE0: set ext_pend; no code_valid.
  - Any other byte: load code, set code_break=break_pend and code_extended=ext_pend, pulse code_valid, clear both pending flags.
- Timeout: in any state other than IDLE, idle_cnt increments every cycle and resets to 0 on fall. When idle_cnt reaches TIMEOUT_CYCLES-1, go to IDLE, pulse frame_error and clear both pending flags.
- The pending flags survive between frames; only a completed non-prefix code, an error or reset clears them.
- Width rules: bit_cnt is 3 bits. idle_cnt is $clog2(TIMEOUT_CYCLES) bits and saturates; it never wraps.

## Timing
- Reset values:
  - state IDLE, bit_cnt 0, idle_cnt 0.
  - Both synchroniser chains and the previous-clk flop reset to 1 (idle bus high), so no spurious fall occurs after reset.
  - code 0x00, code_valid 0, code_break 0, code_extended 0, frame_error 0, break_pend 0, ext_pend 0.
- Latency: a ps2_clk fall first captured by sync stage 1 at rising edge N produces fall during cycle N+1. The resulting state, code_valid or frame_error is registered at edge N+2.
- code_valid and frame_error are each exactly one cycle wide and are never asserted in the same cycle.
- Timeout and fall in the same cycle: fall wins. The bit is taken, idle_cnt clears and no error is raised.
- Reset asserted mid-frame: the partial frame is discarded, no pulse is produced and the FSM is in IDLE on the next cycle.
- Minimum input spacing: PS/2 clock edges arrive no faster than 60 µs apart. No back-pressure is provided or needed.

## Test plan
- Make code: frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> exactly one code_valid with code=0x1C, code_break=0, code_extended=0. frame_error stays 0.
- Break sequence: frame 0xF0 (parity 1) then frame 0x1C -> no code_valid after the 0xF0 frame. One code_valid with code=0x1C, code_break=1. A following 0x1C make frame gives code_break=0.
- Extended break: frames 0xE0, 0xF0, 0x75 -> a single code_valid with code=0x75, code_extended=1, code_break=1.
- Parity error: frame 0xF0, then 0x1C sent with parity 1, then a good 0x1C -> one frame_error pulse and no code_valid for the bad frame. The good frame gives code_valid with code=0x1C and code_break=0 (pending flag cleared by the error).
- Timeout (TIMEOUT_CYCLES=100): start bit plus 4 data bits, then ps2_clk held high -> frame_error pulses 100 cycles after the last fall and the FSM returns to IDLE. The next full 0x1C frame decodes correctly.
- Reset mid-frame: assert reset for 1 cycle after 6 bits of a frame, then send a full 0x23 frame -> no pulse from the aborted frame and all outputs 0 after reset. The 0x23 frame gives code_valid with code=0x23.
